sobel_window: RTL and testbench

- Streaming 3x3 neighbourhood generator that sits directly upstream of the sobel gradient stage.
- Accepts a raster-order pixel stream (one pixel per accepted beat, row-major, top-left first) and buffers two previous image rows in line buffers.
- For every interior pixel position it presents a complete, registered 3x3 window on ports s11..s33 with a valid/ready handshake.
- Indexing is sRC: R = row (1 = oldest/top), C = column (1 = oldest/left). The output ports map one-to-one onto the sobel stage inputs.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buf.sv | 27 ++
 rtl/sobel_window.sv | 170 +++++++++++++++++
 tb/tb_sobel_window.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the sobel 3x3 window generator.
package sobel_pkg;

  localparam int unsigned PIX_W_DEFAULT = 8;

  typedef logic [PIX_W_DEFAULT-1:0] pix_t;

  typedef struct packed {
    pix_t s11;
    pix_t s12;
    pix_t s13;
    pix_t s21;
    pix_t s22;
    pix_t s23;
    pix_t s31;
    pix_t s32;
    pix_t s33;
  } win_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

endpackage

// File: rtl/sobel_line_buf.sv
// Line buffer for the two previous image rows, packed into one word per column.
// Combinational read returns the pre-write word when read and write share an address.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 352,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window.sv
// Streaming 3x3 neighbourhood generator feeding the sobel gradient stage.
// Optional start-of-frame resync and error flag: define SOBEL_WINDOW_SOF_EN.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 352,
  parameter int unsigned IMG_H = 288,
  parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
`ifdef SOBEL_WINDOW_SOF_EN
  input  logic             in_sof,
  output logic             sof_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] s11,
  output logic [PIX_W-1:0] s12,
  output logic [PIX_W-1:0] s13,
  output logic [PIX_W-1:0] s21,
  output logic [PIX_W-1:0] s22,
  output logic [PIX_W-1:0] s23,
  output logic [PIX_W-1:0] s31,
  output logic [PIX_W-1:0] s32,
  output logic [PIX_W-1:0] s33,
  output logic             frame_done
);

  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned LBW = 2 * PIX_W;

  logic [CW-1:0]    col_q, col_d, eff_col;
  logic [RW-1:0]    row_q, row_d, eff_row;
  win_state_e       state_q, state_d, eff_state;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic             accept, consume;
  logic [LBW-1:0]   lb_rdata, lb_wdata;
`ifdef SOBEL_WINDOW_SOF_EN
  logic             sof_err_q, sof_err_d;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  // Effective position of the incoming pixel; a start-of-frame marker overrides the counters.
  always_comb begin
    eff_col   = col_q;
    eff_row   = row_q;
    eff_state = state_q;
`ifdef SOBEL_WINDOW_SOF_EN
    if (in_sof) begin
      eff_col   = '0;
      eff_row   = '0;
      eff_state = FILL;
    end
`endif
  end

  // Upper half holds row-2, lower half row-1; every accept ages both by one row.
  assign lb_wdata = {lb_rdata[PIX_W-1:0], in_pix};

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (LBW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (eff_col),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  // Next-state: counters, fill/run state, window shift and output valid.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
`ifdef SOBEL_WINDOW_SOF_EN
    sof_err_d    = accept && (in_sof != ((col_q == '0) && (row_q == '0)));
`endif

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_rdata[LBW-1:PIX_W];
      win_d[1][2] = lb_rdata[PIX_W-1:0];
      win_d[2][2] = in_pix;

      out_valid_d = (eff_state == RUN) && (eff_col >= CW'(2));

      if (eff_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (eff_row == RW'(IMG_H - 1)) begin
          row_d        = '0;
          state_d      = FILL;
          frame_done_d = 1'b1;
        end else begin
          row_d   = eff_row + RW'(1);
          state_d = (eff_row == RW'(1)) ? RUN : eff_state;
        end
      end else begin
        col_d   = eff_col + CW'(1);
        row_d   = eff_row;
        state_d = eff_state;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= FILL;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
`ifdef SOBEL_WINDOW_SOF_EN
      sof_err_q    <= 1'b0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
`ifdef SOBEL_WINDOW_SOF_EN
      sof_err_q    <= sof_err_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign s11 = win_q[0][0];
  assign s12 = win_q[0][1];
  assign s13 = win_q[0][2];
  assign s21 = win_q[1][0];
  assign s22 = win_q[1][1];
  assign s23 = win_q[1][2];
  assign s31 = win_q[2][0];
  assign s32 = win_q[2][1];
  assign s33 = win_q[2][2];
`ifdef SOBEL_WINDOW_SOF_EN
  assign sof_err = sof_err_q;
`endif

endmodule

// File: tb/tb_sobel_window.sv
// Self-checking bench for sobel_window: 4x4 and 5x3 instances against an image-array model.
`timescale 1ns/1ps
module tb_sobel_window;

  typedef logic [8:0][7:0] win_t;  // [0]=s11 ... [8]=s33
  typedef struct {
    logic [7:0] pix;
    logic       exp_valid;
    logic       exp_fd;
    win_t       exp_win;
  } vec_t;

  logic       clk, rst_n, in_valid, out_ready, in_sof;
  logic [7:0] in_pix;
  logic       rdy4, vld4, fd4, err4, rdy5, vld5, fd5, err5;
  logic [7:0] p4 [9];
  logic [7:0] p5 [9];
  win_t       win4, win5;
  logic       sel;
  logic       o_valid, o_in_ready, o_fd, o_err;
  win_t       o_win;

  int         checks, errors;
  vec_t       tbl [16];
  logic [7:0] img [4][5];
  int         pr, pc, cur_w, cur_h, acc_cnt;
  win_t       exp_q [$];
  win_t       got_q [$];
  logic [7:0] pix_q [$];
  logic       sof_q [$];
  logic       fd_pend, err_pend;
  int         win_cnt, fd_cnt, err_cnt, valid_pct, rmode;
  logic       s_valid, s_in_ready;
  win_t       s_win;

  sobel_window #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_pix(in_pix),
`ifdef SOBEL_WINDOW_SOF_EN
    .in_sof(in_sof), .sof_err(err4),
`endif
    .out_valid(vld4), .out_ready(out_ready),
    .s11(p4[0]), .s12(p4[1]), .s13(p4[2]), .s21(p4[3]), .s22(p4[4]),
    .s23(p4[5]), .s31(p4[6]), .s32(p4[7]), .s33(p4[8]), .frame_done(fd4)
  );

  sobel_window #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy5), .in_pix(in_pix),
`ifdef SOBEL_WINDOW_SOF_EN
    .in_sof(in_sof), .sof_err(err5),
`endif
    .out_valid(vld5), .out_ready(out_ready),
    .s11(p5[0]), .s12(p5[1]), .s13(p5[2]), .s21(p5[3]), .s22(p5[4]),
    .s23(p5[5]), .s31(p5[6]), .s32(p5[7]), .s33(p5[8]), .frame_done(fd5)
  );

`ifndef SOBEL_WINDOW_SOF_EN
  assign err4 = 1'b0;
  assign err5 = 1'b0;
`endif

  assign win4       = {p4[8], p4[7], p4[6], p4[5], p4[4], p4[3], p4[2], p4[1], p4[0]};
  assign win5       = {p5[8], p5[7], p5[6], p5[5], p5[4], p5[3], p5[2], p5[1], p5[0]};
  assign o_valid    = sel ? vld5 : vld4;
  assign o_in_ready = sel ? rdy5 : rdy4;
  assign o_fd       = sel ? fd5 : fd4;
  assign o_err      = sel ? err5 : err4;
  assign o_win      = sel ? win5 : win4;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Window centred on (r-1, c-1), taken straight from the stored image.
  function automatic win_t mkwin(input int r, input int c);
    win_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i*3+j] = img[r-2+i][c-2+j];
    return w;
  endfunction

  task automatic model_reset();
    pr = 0; pc = 0; acc_cnt = 0;
    exp_q.delete(); got_q.delete(); pix_q.delete(); sof_q.delete();
    fd_pend = 0; err_pend = 0; s_valid = 0;
    win_cnt = 0; fd_cnt = 0; err_cnt = 0;
    cur_w = sel ? 5 : 4;
    cur_h = sel ? 3 : 4;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; in_sof = 0; out_ready = 0;
    #1;
    check("rst out_valid", 72'(o_valid), 72'(0));
    check("rst window", 72'(o_win), 72'(0));
    check("rst frame_done", 72'(o_fd), 72'(0));
    check("rst in_ready", 72'(o_in_ready), 72'(1));
    check("rst sof_err", 72'(o_err), 72'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic push_frame(input int base, input int w, input int h, input logic sof_first);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        pix_q.push_back(8'(base + r*16 + c));
        sof_q.push_back((r == 0 && c == 0) ? sof_first : 1'b0);
      end
  endtask

  // One clock: check registered pulses, drive inputs, then resolve the handshake at the coming edge.
  task automatic step();
    @(negedge clk);
    if (o_fd || fd_pend) check("frame_done", 72'(o_fd), 72'(fd_pend));
    if (o_fd) fd_cnt++;
    if (o_err || err_pend) check("sof_err", 72'(o_err), 72'(err_pend));
    if (o_err) err_cnt++;
    fd_pend = 0; err_pend = 0;
    in_valid = (pix_q.size() > 0) && ($urandom_range(99) < valid_pct);
    in_pix   = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
    in_sof   = (sof_q.size() > 0) ? sof_q[0] : 1'b0;
    out_ready = (rmode == 2) ? 1'($urandom_range(1)) : (rmode == 1);
    #1;
    s_valid = o_valid; s_in_ready = o_in_ready; s_win = o_win;
    if (o_valid && out_ready) begin
      win_cnt++;
      got_q.push_back(o_win);
      if (exp_q.size() == 0) check("unexpected window", 72'(o_win), 72'(0));
      else check("window", 72'(o_win), 72'(exp_q.pop_front()));
    end
    if (in_valid && o_in_ready) begin
`ifdef SOBEL_WINDOW_SOF_EN
      err_pend = (in_sof != (pr == 0 && pc == 0));
      if (in_sof) begin pr = 0; pc = 0; end
`endif
      img[pr][pc] = in_pix;
      if (pr >= 2 && pc >= 2) exp_q.push_back(mkwin(pr, pc));
      fd_pend = (pr == cur_h - 1) && (pc == cur_w - 1);
      if (pc == cur_w - 1) begin
        pc = 0;
        pr = (pr == cur_h - 1) ? 0 : pr + 1;
      end else pc++;
      acc_cnt++;
      void'(pix_q.pop_front());
      void'(sof_q.pop_front());
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(pix_q.size() == 0 && exp_q.size() == 0 && !s_valid) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) fail_now(name);
    repeat (3) step();
  endtask

  initial begin
    int n;
    logic mix;
    win_t hold;
    clk = 0; rst_n = 0; in_valid = 0; in_pix = 0; in_sof = 0; out_ready = 0; sel = 0;
    checks = 0; errors = 0; valid_pct = 100; rmode = 1;
    model_reset();

    for (int k = 0; k < 16; k++) begin
      tbl[k].pix = 8'((k / 4) * 16 + k % 4);
      tbl[k].exp_valid = 1'b0;
      tbl[k].exp_fd = 1'b0;
      tbl[k].exp_win = '0;
    end
    tbl[10].exp_valid = 1'b1;
    tbl[10].exp_win = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    tbl[11].exp_valid = 1'b1;
    tbl[11].exp_win = {8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11, 8'h03, 8'h02, 8'h01};
    tbl[14].exp_valid = 1'b1;
    tbl[14].exp_win = {8'h32, 8'h31, 8'h30, 8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10};
    tbl[15].exp_valid = 1'b1;
    tbl[15].exp_fd = 1'b1;
    tbl[15].exp_win = {8'h33, 8'h32, 8'h31, 8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11};

    apply_reset();

    // Directed 4x4 frame, continuous valid and ready.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_valid = 1; in_pix = tbl[k].pix; in_sof = 0; out_ready = 1;
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d] in_ready", k), 72'(o_in_ready), 72'(1));
      check($sformatf("tbl[%0d] out_valid", k), 72'(o_valid), 72'(tbl[k].exp_valid));
      check($sformatf("tbl[%0d] frame_done", k), 72'(o_fd), 72'(tbl[k].exp_fd));
      if (tbl[k].exp_valid) check($sformatf("tbl[%0d] window", k), 72'(o_win), 72'(tbl[k].exp_win));
    end
    @(negedge clk);
    in_valid = 0;

    // Downstream stall right after the first window.
    apply_reset();
    push_frame(0, 4, 4, 1'b0);
    valid_pct = 100; rmode = 0;
    n = 0;
    while (!s_valid && n < 100) begin step(); n++; end
    if (!s_valid || exp_q.size() == 0) fail_now("stall first window");
    else begin
      hold = exp_q[0];
      for (int i = 0; i < 5; i++) begin
        step();
        check("stall in_ready", 72'(s_in_ready), 72'(0));
        check("stall out_valid", 72'(s_valid), 72'(1));
        check("stall window", 72'(s_win), 72'(hold));
      end
    end
    rmode = 1;
    drain("stall drain");
    check("stall window count", 72'(win_cnt), 72'(4));
    check("stall frame_done count", 72'(fd_cnt), 72'(1));

    // Two back-to-back frames under random valid/ready.
    apply_reset();
    push_frame(0, 4, 4, 1'b0);
    push_frame(8'h80, 4, 4, 1'b0);
    valid_pct = 50; rmode = 2;
    drain("random drain");
    check("random window count", 72'(win_cnt), 72'(8));
    check("random frame_done count", 72'(fd_cnt), 72'(2));
    mix = 1'b0;
    foreach (got_q[i])
      for (int j = 1; j < 9; j++)
        if (got_q[i][j][7] != got_q[i][0][7]) mix = 1'b1;
    check("frame mix", 72'(mix), 72'(0));
    if (got_q.size() >= 5) check("frame2 first s11", 72'(got_q[4][0]), 72'(8'h80));
    else fail_now("frame2 first window");

    // Reset after pixel 0x21, then a clean frame.
    apply_reset();
    push_frame(0, 4, 4, 1'b0);
    valid_pct = 100; rmode = 1;
    n = 0;
    while (acc_cnt < 10 && n < 100) begin step(); n++; end
    if (acc_cnt < 10) fail_now("midframe accept");
    apply_reset();
    push_frame(0, 4, 4, 1'b0);
    drain("post-reset drain");
    check("post-reset window count", 72'(win_cnt), 72'(4));

    // 5x3 image: three windows on row 1.
    sel = 1;
    apply_reset();
    push_frame(0, 5, 3, 1'b0);
    valid_pct = 100; rmode = 1;
    drain("5x3 drain");
    check("5x3 window count", 72'(win_cnt), 72'(3));
    check("5x3 frame_done count", 72'(fd_cnt), 72'(1));
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) check($sformatf("5x3 centre %0d", i), 72'(got_q[i][4]), 72'(8'h11 + i));
    sel = 0;

`ifdef SOBEL_WINDOW_SOF_EN
    // Early SOF on the 6th pixel restarts the frame.
    apply_reset();
    pix_q.push_back(8'hE0); sof_q.push_back(1'b1);
    for (int i = 1; i < 5; i++) begin pix_q.push_back(8'(8'hE0 + i)); sof_q.push_back(1'b0); end
    push_frame(8'h40, 4, 4, 1'b1);
    valid_pct = 100; rmode = 1;
    drain("sof drain");
    check("sof_err count", 72'(err_cnt), 72'(1));
    check("sof window count", 72'(win_cnt), 72'(4));
    if (got_q.size() > 0) check("sof first s11", 72'(got_q[0][0]), 72'(8'h40));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
